// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
// State encoding, redirect source tags and the sequential PC step.
package pc_seq_pkg;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_TRAP
  } src_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the next PC: trap > jump > branch > pc+4.
// Ports: pc, br_taken/br_target, jmp/jmp_target in; redir, nxt, trap, bad out.
// PC_SEQ_TRAP_EN: misaligned redirect targets go to TRAP_VEC.
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WORD     = 32,
  parameter logic [WORD-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [WORD-1:0] pc,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  input  logic            jmp,
  input  logic [WORD-1:0] jmp_target,
  output logic            redir,
  output logic [WORD-1:0] nxt,
  output logic            trap,
  output logic [WORD-1:0] bad
);

  src_e            src;
  logic [WORD-1:0] raw;
  logic            mis;

  always_comb begin
    src = SRC_SEQ;
    raw = pc + WORD'(PC_INC);
    if (jmp) begin
      src = SRC_JMP;
      raw = jmp_target;
    end else if (br_taken) begin
      src = SRC_BR;
      raw = br_target;
    end
`ifdef PC_SEQ_TRAP_EN
    mis = (src != SRC_SEQ) && (raw[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) src = SRC_TRAP;
    unique case (src)
      SRC_TRAP: nxt = TRAP_VEC;
      SRC_SEQ:  nxt = raw;
      default:  nxt = {raw[WORD-1:2], 2'b00};
    endcase
  end

  assign redir = jmp | br_taken;
  assign trap  = mis;
  assign bad   = raw;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller and imem fetch sequencer (BOOT/REQ/WAIT/HALT).
// In: clk_i, rst_ni, stall_i, br_*, jmp_*, halt_i, imem_ack_i, imem_data_i.
// Out: imem_req_o/addr_o, instr_o/valid_o, pc_o, pc_next_o, pc_we_o,
//      trap_o, epc_o. Macro PC_SEQ_TRAP_EN enables misalignment traps.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [WORD-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [WORD-1:0] jmp_target_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [WORD-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [WORD-1:0] imem_data_i,
  output logic [WORD-1:0] instr_o,
  output logic            instr_valid_o,
  output logic [WORD-1:0] pc_o,
  output logic [WORD-1:0] pc_next_o,
  output logic            pc_we_o,
  output logic            trap_o,
  output logic [WORD-1:0] epc_o
);

  state_e          state, state_n;
  logic [WORD-1:0] pc_q, instr_q, epc_q;
  logic [WORD-1:0] pend_pc_q, pend_bad_q;
  logic            valid_q, trap_q, halt_q;
  logic            pend_q, pend_trap_q;

  logic            redir, mux_trap;
  logic [WORD-1:0] mux_nxt, mux_bad;

  logic            req, we, deliver;
  logic            app_trap, pend_set;
  logic            pend_clr, halt_set;
  logic [WORD-1:0] nxt, app_bad;

  pc_redirect_mux #(
    .WORD    (WORD),
    .TRAP_VEC(TRAP_VEC)
  ) u_mux (
    .pc        (pc_q),
    .br_taken  (br_taken_i),
    .br_target (br_target_i),
    .jmp       (jmp_i),
    .jmp_target(jmp_target_i),
    .redir     (redir),
    .nxt       (mux_nxt),
    .trap      (mux_trap),
    .bad       (mux_bad)
  );

  always_comb begin
    state_n  = state;
    req      = 1'b0;
    we       = 1'b0;
    deliver  = 1'b0;
    nxt      = pc_q;
    app_trap = 1'b0;
    app_bad  = '0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    halt_set = 1'b0;
    unique case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (halt_i || halt_q) begin
          state_n = HALT;
        end else if (stall_i) begin
          // Redirect seen while stalled waits here.
          pend_set = redir && !pend_q;
        end else if (pend_q) begin
          we       = 1'b1;
          nxt      = pend_pc_q;
          app_trap = pend_trap_q;
          app_bad  = pend_bad_q;
          pend_clr = 1'b1;
        end else if (redir) begin
          // Load the target now; fetch from it next cycle.
          we       = 1'b1;
          nxt      = mux_nxt;
          app_trap = mux_trap;
          app_bad  = mux_bad;
        end else begin
          req     = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        req      = 1'b1;
        halt_set = halt_i;
        if (imem_ack_i) begin
          we       = 1'b1;
          pend_clr = 1'b1;
          if (pend_q) begin
            nxt      = pend_pc_q;
            app_trap = pend_trap_q;
            app_bad  = pend_bad_q;
          end else if (redir) begin
            nxt      = mux_nxt;
            app_trap = mux_trap;
            app_bad  = mux_bad;
          end else begin
            nxt     = mux_nxt;
            deliver = 1'b1;
          end
          state_n = (halt_i || halt_q) ? HALT : REQ;
        end else begin
          // Oldest redirect wins; younger ones are wrong-path.
          pend_set = redir && !pend_q;
        end
      end
      HALT: state_n = HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      trap_q      <= 1'b0;
      epc_q       <= '0;
      halt_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_pc_q   <= '0;
      pend_bad_q  <= '0;
    end else begin
      state   <= state_n;
      valid_q <= deliver;
      trap_q  <= we && app_trap;
      if (we) pc_q <= nxt;
      if (deliver) instr_q <= imem_data_i;
      if (we && app_trap) epc_q <= app_bad;
      if (halt_set) halt_q <= 1'b1;
      if (pend_clr) begin
        pend_q <= 1'b0;
      end else if (pend_set) begin
        pend_q      <= 1'b1;
        pend_pc_q   <= mux_nxt;
        pend_trap_q <= mux_trap;
        pend_bad_q  <= mux_bad;
      end
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_next_o     = nxt;
  assign pc_we_o       = we;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign trap_o        = trap_q;
  assign epc_o         = epc_q;

endmodule
